// File: rtl/icache_ctrl_if.sv
// Bus interfaces for the instruction-cache controller.
//
// icache_cpu_if : CPU fetch port.
//   cpu_req   - fetch request this cycle              (CPU -> cache)
//   cpu_addr  - word address, held while stalled      (CPU -> cache)
//   cpu_rdata - fetched instruction                   (cache -> CPU)
//   cpu_valid - cpu_rdata valid this cycle            (cache -> CPU)
//   cpu_stall - fetch not satisfied, CPU must hold    (cache -> CPU)
//   master = CPU side, slave = cache side.
//
// icache_mem_if : word-serial read port to the instruction ROM.
//   mem_req   - read request                          (cache -> memory)
//   mem_addr  - word address of the read              (cache -> memory)
//   mem_ready - read accepted, mem_rdata valid        (memory -> cache)
//   mem_rdata - read data                             (memory -> cache)
//   master = cache side, slave = memory side.

interface icache_cpu_if #(
    parameter int ADDR_W = 32
) ();
    logic              cpu_req;
    logic [ADDR_W-1:0] cpu_addr;
    logic [31:0]       cpu_rdata;
    logic              cpu_valid;
    logic              cpu_stall;

    modport master (
        output cpu_req,
        output cpu_addr,
        input  cpu_rdata,
        input  cpu_valid,
        input  cpu_stall
    );

    modport slave (
        input  cpu_req,
        input  cpu_addr,
        output cpu_rdata,
        output cpu_valid,
        output cpu_stall
    );
endinterface

interface icache_mem_if #(
    parameter int ADDR_W = 32
) ();
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ready;
    logic [31:0]       mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ready,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ready,
        output mem_rdata
    );
endinterface

// File: rtl/icache_ctrl.sv
// Direct-mapped instruction-cache controller.
//
// Hits are answered combinationally in the request cycle. A miss stalls the
// CPU and refills the whole line word by word (word 0 upward) over the
// req/ready memory port, then spends one cycle (DONE) returning the missed
// word before going back to IDLE.
//
// Ports:
//   clk       - rising-edge clock
//   reset     - synchronous, active-high
//   cpu       - CPU fetch port (icache_cpu_if.slave)
//   flush     - invalidate all lines (deferred to the end of a refill)
//   mem       - instruction memory read port (icache_mem_if.master)
//   hit_cnt   - hits since reset, wrapping
//   miss_cnt  - misses since reset, wrapping

module icache_ctrl #(
    parameter int LINES          = 16,
    parameter int WORDS_PER_LINE = 4,
    parameter int ADDR_W         = 32
) (
    input  logic               clk,
    input  logic               reset,
    icache_cpu_if.slave        cpu,
    input  logic               flush,
    icache_mem_if.master       mem,
    output logic [31:0]        hit_cnt,
    output logic [31:0]        miss_cnt
);

    localparam int OW = $clog2(WORDS_PER_LINE);
    localparam int IW = $clog2(LINES);
    localparam int TW = ADDR_W - OW - IW;

    localparam logic [OW-1:0] CNT_ONE  = {{(OW-1){1'b0}}, 1'b1};
    localparam logic [OW-1:0] CNT_LAST = OW'(WORDS_PER_LINE - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REFILL = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t              state_r;
    logic [LINES-1:0]    valid_r;
    logic [TW-1:0]       tag_r  [LINES];
    logic [31:0]         data_r [LINES*WORDS_PER_LINE];
    logic [ADDR_W-1:0]   miss_addr_r;
    logic [OW-1:0]       cnt_r;
    logic                flush_pend_r;
    logic [31:0]         hit_cnt_r;
    logic [31:0]         miss_cnt_r;

    logic [OW-1:0]       req_off_s;
    logic [IW-1:0]       req_idx_s;
    logic [TW-1:0]       req_tag_s;
    logic [OW-1:0]       miss_off_s;
    logic [IW-1:0]       miss_idx_s;
    logic [TW-1:0]       miss_tag_s;
    logic                lookup_s;
    logic                hit_s;
    logic                miss_s;
    logic                beat_s;
    logic                last_beat_s;

    assign req_off_s  = cpu.cpu_addr[OW-1:0];
    assign req_idx_s  = cpu.cpu_addr[OW +: IW];
    assign req_tag_s  = cpu.cpu_addr[ADDR_W-1:OW+IW];
    assign miss_off_s = miss_addr_r[OW-1:0];
    assign miss_idx_s = miss_addr_r[OW +: IW];
    assign miss_tag_s = miss_addr_r[ADDR_W-1:OW+IW];

    // Only IDLE looks up the arrays; the other states work from miss_addr_r.
    assign lookup_s    = (state_r == ST_IDLE) && cpu.cpu_req;
    assign hit_s       = lookup_s && valid_r[req_idx_s] && (tag_r[req_idx_s] == req_tag_s);
    assign miss_s      = lookup_s && !hit_s;
    // mem_ready outside REFILL is not a handshake and is ignored.
    assign beat_s      = (state_r == ST_REFILL) && mem.mem_ready;
    assign last_beat_s = beat_s && (cnt_r == CNT_LAST);

    assign mem.mem_req  = (state_r == ST_REFILL);
    assign mem.mem_addr = {miss_addr_r[ADDR_W-1:OW], cnt_r};
    assign hit_cnt      = hit_cnt_r;
    assign miss_cnt     = miss_cnt_r;

    // CPU-side response: same-cycle hit data, stall on miss/refill, missed word in DONE.
    always_comb begin
        cpu.cpu_valid = 1'b0;
        cpu.cpu_stall = 1'b0;
        cpu.cpu_rdata = 32'd0;
        case (state_r)
            ST_IDLE: begin
                if (hit_s) begin
                    cpu.cpu_valid = 1'b1;
                    cpu.cpu_rdata = data_r[{req_idx_s, req_off_s}];
                end else if (miss_s) begin
                    cpu.cpu_stall = 1'b1;
                end else begin
                    cpu.cpu_valid = 1'b0;
                end
            end
            ST_REFILL: begin
                cpu.cpu_stall = 1'b1;
            end
            ST_DONE: begin
                cpu.cpu_valid = 1'b1;
                cpu.cpu_rdata = data_r[{miss_idx_s, miss_off_s}];
            end
            default: begin
                cpu.cpu_valid = 1'b0;
            end
        endcase
    end

    // Refill beats land in the data array; the tag is written with the final beat.
    always_ff @(posedge clk) begin
        if (!reset && beat_s) begin
            data_r[{miss_idx_s, cnt_r}] <= mem.mem_rdata;
            if (last_beat_s) begin
                tag_r[miss_idx_s] <= miss_tag_s;
            end
        end
    end

    // Refill FSM, valid bits, deferred flush and hit/miss counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            valid_r      <= '0;
            miss_addr_r  <= '0;
            cnt_r        <= '0;
            flush_pend_r <= 1'b0;
            hit_cnt_r    <= 32'd0;
            miss_cnt_r   <= 32'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    // A hit in the flush cycle has already been served from the old state.
                    if (flush) begin
                        valid_r <= '0;
                    end
                    if (hit_s) begin
                        hit_cnt_r <= hit_cnt_r + 32'd1;
                    end else if (miss_s) begin
                        miss_cnt_r  <= miss_cnt_r + 32'd1;
                        miss_addr_r <= cpu.cpu_addr;
                        cnt_r       <= '0;
                        state_r     <= ST_REFILL;
                    end
                end
                ST_REFILL: begin
                    if (flush) begin
                        flush_pend_r <= 1'b1;
                    end
                    if (beat_s) begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                    if (last_beat_s) begin
                        valid_r[miss_idx_s] <= 1'b1;
                        state_r             <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // A flush seen during the refill also drops the line just filled.
                    if (flush_pend_r || flush) begin
                        valid_r <= '0;
                    end
                    flush_pend_r <= 1'b0;
                    state_r      <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_icache_ctrl.sv
// Testbench for icache_ctrl (LINES=16, WORDS_PER_LINE=4, ADDR_W=32).
// A line-level cache model (valid/tag per line, pending refill beats as a
// queue of addresses) predicts the outputs on every falling edge; directed
// fetches add literal expectations for stall length, data and counters.

module tb_icache_ctrl;

    localparam int LINES  = 16;
    localparam int WPL    = 4;
    localparam int ADDR_W = 32;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;

    icache_cpu_if #(.ADDR_W(ADDR_W)) cpu_bus ();
    icache_mem_if #(.ADDR_W(ADDR_W)) mem_bus ();

    icache_ctrl #(
        .LINES          (LINES),
        .WORDS_PER_LINE (WPL),
        .ADDR_W         (ADDR_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .cpu      (cpu_bus),
        .flush    (flush),
        .mem      (mem_bus),
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int gap    = 1;
    bit junk   = 1'b0;
    int w      = 0;

    function automatic logic [31:0] rom(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    assign mem_bus.mem_rdata = rom(mem_bus.mem_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- line-level model ----------------
    bit          m_valid [LINES];
    logic [31:0] m_tag   [LINES];
    logic [31:0] m_beats [$];
    bit          m_deliver;
    bit          m_fpend;
    logic [31:0] m_addr;
    int          m_hits;
    int          m_misses;

    function automatic int line_of(input logic [31:0] a);
        return int'((a / WPL) % LINES);
    endfunction

    function automatic logic [31:0] tag_of(input logic [31:0] a);
        return a / (WPL * LINES);
    endfunction

    always @(negedge clk) begin
        logic [31:0] a;
        bit h;
        a = cpu_bus.cpu_addr;
        if (reset) begin
            foreach (m_valid[i]) m_valid[i] = 1'b0;
            m_beats.delete();
            m_deliver = 1'b0;
            m_fpend   = 1'b0;
            m_hits    = 0;
            m_misses  = 0;
        end else begin
            h = cpu_bus.cpu_req && m_valid[line_of(a)] && (m_tag[line_of(a)] == tag_of(a));
            if (m_beats.size() > 0) begin
                chk("refill_mem_req", {31'd0, mem_bus.mem_req}, 32'd1);
                chk("refill_mem_addr", mem_bus.mem_addr, m_beats[0]);
                chk("refill_stall", {31'd0, cpu_bus.cpu_stall}, 32'd1);
                chk("refill_valid", {31'd0, cpu_bus.cpu_valid}, 32'd0);
            end else if (m_deliver) begin
                chk("done_valid", {31'd0, cpu_bus.cpu_valid}, 32'd1);
                chk("done_stall", {31'd0, cpu_bus.cpu_stall}, 32'd0);
                chk("done_rdata", cpu_bus.cpu_rdata, rom(m_addr));
                chk("done_mem_req", {31'd0, mem_bus.mem_req}, 32'd0);
            end else begin
                chk("idle_mem_req", {31'd0, mem_bus.mem_req}, 32'd0);
                chk("idle_valid", {31'd0, cpu_bus.cpu_valid}, {31'd0, h});
                chk("idle_stall", {31'd0, cpu_bus.cpu_stall}, {31'd0, cpu_bus.cpu_req && !h});
                if (h) begin
                    chk("hit_rdata", cpu_bus.cpu_rdata, rom(a));
                end
            end
            chk("hit_cnt", hit_cnt, m_hits);
            chk("miss_cnt", miss_cnt, m_misses);

            // advance the model to what holds after the coming rising edge
            if (m_beats.size() > 0) begin
                if (flush) m_fpend = 1'b1;
                if (mem_bus.mem_ready) begin
                    void'(m_beats.pop_front());
                    if (m_beats.size() == 0) begin
                        m_valid[line_of(m_addr)] = 1'b1;
                        m_tag[line_of(m_addr)]   = tag_of(m_addr);
                        m_deliver = 1'b1;
                    end
                end
            end else if (m_deliver) begin
                m_deliver = 1'b0;
                if (m_fpend || flush) foreach (m_valid[i]) m_valid[i] = 1'b0;
                m_fpend = 1'b0;
            end else begin
                if (cpu_bus.cpu_req) begin
                    if (h) begin
                        m_hits++;
                    end else begin
                        m_misses++;
                        m_addr = a;
                        for (int i = 0; i < WPL; i++) m_beats.push_back((a / WPL) * WPL + i);
                    end
                end
                if (flush) foreach (m_valid[i]) m_valid[i] = 1'b0;
            end
        end
    end

    // ---------------- stimulus ----------------
    // One clock; the memory answers after `gap` cycles of mem_req, and with
    // `junk` set it also raises mem_ready while no request is pending.
    task automatic tick();
        logic was_req;
        logic was_ready;
        was_req   = mem_bus.mem_req;
        was_ready = mem_bus.mem_ready;
        @(posedge clk);
        #1;
        if (was_req !== 1'b1 || was_ready === 1'b1) w = 0;
        else w++;
        if (mem_bus.mem_req === 1'b1) mem_bus.mem_ready = (w == gap - 1);
        else mem_bus.mem_ready = junk;
    endtask

    task automatic fetch(input logic [31:0] addr, input int exp_stall,
                         input int flush_at, input string name);
        int stalls;
        bit got;
        stalls = 0;
        got    = 1'b0;
        cpu_bus.cpu_req  = 1'b1;
        cpu_bus.cpu_addr = addr;
        for (int cyc = 0; cyc < 100; cyc++) begin
            flush = (cyc == flush_at);
            #1;
            if (cpu_bus.cpu_valid === 1'b1) begin
                got = 1'b1;
                break;
            end
            stalls++;
            tick();
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: no cpu_valid within 100 cycles", name);
        end else begin
            chk({name, "_stall"}, stalls, exp_stall);
            chk({name, "_data"}, cpu_bus.cpu_rdata, rom(addr));
        end
        tick();
        cpu_bus.cpu_req = 1'b0;
        flush = 1'b0;
    endtask

    initial begin
        cpu_bus.cpu_req   = 1'b0;
        cpu_bus.cpu_addr  = 32'd0;
        mem_bus.mem_ready = 1'b0;
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        chk("rst_mem_req", {31'd0, mem_bus.mem_req}, 32'd0);
        chk("rst_valid", {31'd0, cpu_bus.cpu_valid}, 32'd0);
        chk("rst_stall", {31'd0, cpu_bus.cpu_stall}, 32'd0);
        chk("rst_hits", hit_cnt, 32'd0);
        chk("rst_misses", miss_cnt, 32'd0);

        // cold miss, then hit in the same line
        fetch(32'h10, 5, -1, "cold");
        chk("cold_miss_cnt", miss_cnt, 32'd1);
        fetch(32'h12, 0, -1, "hit");
        chk("hit_hit_cnt", hit_cnt, 32'd1);

        // conflict on index 4
        fetch(32'h50, 5, -1, "conflict");
        fetch(32'h10, 5, -1, "evicted");
        fetch(32'h13, 0, -1, "rehit");
        chk("conflict_miss_cnt", miss_cnt, 32'd3);
        chk("conflict_hit_cnt", hit_cnt, 32'd2);
        tick();

        // slow memory with spurious ready while idle
        gap  = 3;
        junk = 1'b1;
        fetch(32'h24, 13, -1, "slow");
        fetch(32'h27, 0, -1, "slow_hit");
        tick();
        gap = 1;

        // flush at beat 2 of a refill
        fetch(32'h44, 5, 3, "flush_refill");
        fetch(32'h44, 5, -1, "after_flush");
        fetch(32'h13, 5, -1, "flushed_other");
        chk("flush_miss_cnt", miss_cnt, 32'd7);

        // flush in IDLE alongside a hit
        fetch(32'h11, 0, 0, "flush_hit");
        fetch(32'h11, 5, -1, "post_flush");
        chk("flush_idle_hit_cnt", hit_cnt, 32'd4);
        chk("flush_idle_miss_cnt", miss_cnt, 32'd8);
        junk = 1'b0;
        tick();

        // reset while beat 1 of a refill is on the bus
        cpu_bus.cpu_req  = 1'b1;
        cpu_bus.cpu_addr = 32'h30;
        tick();
        tick();
        reset = 1'b1;
        cpu_bus.cpu_req = 1'b0;
        tick();
        chk("midrst_mem_req", {31'd0, mem_bus.mem_req}, 32'd0);
        chk("midrst_hits", hit_cnt, 32'd0);
        chk("midrst_misses", miss_cnt, 32'd0);
        reset = 1'b0;
        tick();
        fetch(32'h30, 5, -1, "after_rst");
        chk("after_rst_miss_cnt", miss_cnt, 32'd1);

        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
